arbiter4_ingress_buf: RTL
=========================

# arbiter4_ingress_buf

Four independent per-requester FIFOs that sit directly upstream of the 4-way pipelined arbiter. Each channel buffers its own source stream and presents `valid`/`data` to the arbiter's `valid_in`/`data_in` slice. It pops only when the arbiter's matching `ready_out` bit is high. This decouples bursty sources from arbitration stalls, so a requester losing arbitration does not back-pressure its producer until its FIFO fills.

## Interface
- `DW`, default 8: data width per channel.
- `DEPTH`, default 4: entries per channel FIFO. Must be a power of two, at least 2.
- `AW`, default log2(`DEPTH`): derived pointer width. Not overridden by users.
- `clk` (input, 1): single clock, rising edge.
- `rst` (input, 1): reset, asynchronous assert, active-low. Active when 0. Release is synchronous to `clk`.
- `s_valid` (input, 4): per-channel source valid.
- `s_data` (input, 4*DW): channel i occupies bits [i*DW +: DW].
- `s_ready` (output, 4): per-channel "can accept".
- `m_valid` (output, 4): per-channel head valid. Connects to arbiter `valid_in`.
- `m_data` (output, 4*DW): per-channel head data, same packing as `s_data`. Connects to arbiter `data_in`.
- `m_ready` (input, 4): per-channel pop enable. Connects to arbiter `ready_out`.
- `level` (output, 4*(AW+1)): per-channel occupancy, 0..DEPTH. Channel i is at bits [i*(AW+1) +: AW+1].

## Operation
- Channels are fully independent. There is no cross-channel interaction.
- Push on channel i when `s_valid[i] && s_ready[i]` at a rising edge. Data is written at the write pointer, which then increments modulo DEPTH.
- Pop on channel i when `m_valid[i] && m_ready[i]` at a rising edge. The read pointer increments modulo DEPTH.
- First-word-fall-through:
  - `m_data` slice i always shows the entry at the read pointer.
  - `m_valid[i] = (level_i != 0)`.
- `s_ready[i] = (level_i != DEPTH)`. Both `s_ready` and `m_valid` are decoded from registered state only. There is no combinational path from `m_ready` to `s_ready`, or from `s_valid` to `m_valid`.
- Occupancy update per cycle:
  - push only: `level` +1.
  - pop only: `level` −1.
  - push and pop together: `level` unchanged, and both pointers advance.
- Full channel: `s_ready` is 0, so no push is accepted, even if a pop occurs in the same cycle. `s_ready` rises the cycle after the pop.
- Empty channel: `m_valid` is 0, so `m_ready` is ignored. There is no bypass; a push becomes visible at the head one cycle later.
- `m_ready` asserted while `m_valid` is 0: no effect. Pointers and level hold.
- Pointer wrap: pointers are AW bits wide and wrap DEPTH−1 → 0 naturally. Full versus empty is resolved by the AW+1-bit `level`, not by pointer comparison.

## Timing
- Reset values (while `rst`=0 and immediately after release):
  - `level` = 0, pointers = 0, `m_valid` = 4'b0000.
  - `s_ready` = 4'b0000 while `rst`=0, then 4'b1111 after release.
  - Storage is cleared to 0, so `m_data` = 0.
- Reset asserted mid-operation discards all buffered entries immediately (asynchronously). No pop or push completes on that edge.
- Latency from push to head: 1 cycle. Data accepted at edge N appears on `m_data` with `m_valid`=1 after edge N.
- Full-throughput steady state: one push and one pop per channel per cycle, with no bubbles, whenever 0 < level < DEPTH.
- Latency from pop to `s_ready` recovery: 1 cycle.

## Structure
- Shared package holds:
  - `NCH` = 4 channels.
  - A `clog2` function for deriving `AW`.
  - Slice helper macros and constants for the DW and level packing. The arbiter shares the DW packing.
- One sub-module, `arbiter4_ingress_fifo`: a single-channel FWFT FIFO with DW/DEPTH parameters, ports `clk`, `rst`, `s_valid`, `s_data`, `s_ready`, `m_valid`, `m_data`, `m_ready`, `level`. The top instantiates it four times in a generate loop and does slice wiring only.

## Test plan
- **Reset:** hold `rst`=0 with `s_valid`=4'b1111 → `s_ready`=0, `m_valid`=0, `m_data`=0, all levels 0. Release → `s_ready`=4'b1111.
- **Single pass-through:** ch0 pushes 8'h01 with `m_ready`=0 → next cycle `m_valid`=4'b0001, `m_data`[7:0]=8'h01, ch0 level=1. Raise `m_ready[0]` for one cycle → `m_valid[0]`=0 and level=0.
- **Fill and stall:** ch2 pushes 8'h21,22,23,24 with `m_ready`=0 → level=4, `s_ready[2]`=0. A fifth push of 8'h25 is refused. Pop four times → head order is 21, 22, 23, 24.
- **Simultaneous push and pop with wrap:** ch1 at level 2, then push and pop every cycle for 10 cycles with values 8'h10..8'h19 → level stays 2, output order is preserved across pointer wrap, and there are no bubbles.
- **Full plus pop same cycle:** ch3 full, `s_valid[3]`=1, `m_ready[3]`=1 → push refused that cycle, level=3. `s_ready[3]`=1 the next cycle.
- **Independence and mid-run reset:** interleave traffic on all four channels with distinct data (ch i = 8'h{i}0..). Assert `rst`=0 mid-burst → all levels 0 and `m_valid`=0 immediately. After release, channels resume from empty.

Source files
------------

// File: rtl/arbiter4_ingress_buf_pkg.sv
// Shared constants, pointer-width helper and bus slice macros for the
// 4-way arbiter ingress buffer.
`ifndef ARBITER4_INGRESS_BUF_PKG_SV
`define ARBITER4_INGRESS_BUF_PKG_SV

// Channel i's data slice of a packed NCH*DW bus (same packing the arbiter uses).
`define A4IB_DSLICE(i, dw) ((i)*(dw)) +: (dw)
// Channel i's occupancy slice of a packed NCH*(AW+1) level bus.
`define A4IB_LSLICE(i, aw) ((i)*((aw)+1)) +: ((aw)+1)

package arbiter4_ingress_buf_pkg;

    localparam int NCH = 4;

    function automatic int clog2(input int n);
        int r;
        for (r = 0; (1 << r) < n; r++) begin
        end
        return r;
    endfunction

endpackage

`endif

// File: rtl/arbiter4_ingress_fifo.sv
// Single-channel first-word-fall-through FIFO; the head entry is always
// visible on m_data and occupancy is tracked by an explicit level counter.
module arbiter4_ingress_fifo
    import arbiter4_ingress_buf_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    input  logic          m_ready,
    output logic [AW:0]   level
);

    logic [DW-1:0] mem_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   level_reg;
    logic          push;
    logic          pop;

    // Full/empty come from the level counter only, so pointers may wrap freely.
    assign m_valid = (level_reg != '0);
    assign s_ready = rst && (level_reg != (AW+1)'(DEPTH));
    assign m_data  = mem_reg[rd_ptr_reg];
    assign level   = level_reg;

    assign push = s_valid && s_ready;
    assign pop  = m_valid && m_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                mem_reg[wr_ptr_reg] <= s_data;
                wr_ptr_reg          <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   level_reg <= level_reg + (AW+1)'(1);
                2'b01:   level_reg <= level_reg - (AW+1)'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/arbiter4_ingress_buf.sv
// Four independent FWFT FIFOs in front of the 4-way arbiter; this level only
// slices the packed buses onto the per-channel instances.
module arbiter4_ingress_buf
    import arbiter4_ingress_buf_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCH-1:0]          s_valid,
    input  logic [NCH*DW-1:0]       s_data,
    output logic [NCH-1:0]          s_ready,
    output logic [NCH-1:0]          m_valid,
    output logic [NCH*DW-1:0]       m_data,
    input  logic [NCH-1:0]          m_ready,
    output logic [NCH*(AW+1)-1:0]   level
);

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        arbiter4_ingress_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .s_valid (s_valid[gi]),
            .s_data  (s_data[`A4IB_DSLICE(gi, DW)]),
            .s_ready (s_ready[gi]),
            .m_valid (m_valid[gi]),
            .m_data  (m_data[`A4IB_DSLICE(gi, DW)]),
            .m_ready (m_ready[gi]),
            .level   (level[`A4IB_LSLICE(gi, AW)])
        );
    end

endmodule
